// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and debounces the pin pair, then
// deframes 11-bit frames into scan-code bytes with valid/error strobes.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] clk_hist;
    logic [FILTER_LEN-1:0] data_hist;
    logic                  clk_f;
    logic                  clk_f_d;
    logic                  data_f;
    logic                  fall;

    state_t                state;
    logic [2:0]            bit_idx;
    logic [7:0]            shift;
    logic                  parity;
    logic [CNT_W-1:0]      to_cnt;

    // Two-flop synchronizers, history filters and filtered-level edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_hist  <= '1;
            data_hist <= '1;
            clk_f     <= 1'b1;
            clk_f_d   <= 1'b1;
            data_f    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_hist  <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
            data_hist <= {data_hist[FILTER_LEN-2:0], data_sync[1]};
            if (&clk_hist)
                clk_f <= 1'b1;
            else if (~|clk_hist)
                clk_f <= 1'b0;
            if (&data_hist)
                data_f <= 1'b1;
            else if (~|data_hist)
                data_f <= 1'b0;
            clk_f_d <= clk_f;
        end
    end

    assign fall = clk_f_d & ~clk_f;
    assign busy = (state != IDLE);

    // Frame FSM; a filtered falling edge always beats the timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            parity  <= 1'b0;
            to_cnt  <= '0;
            data    <= 8'h00;
            valid   <= 1'b0;
            error   <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_f) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift[bit_idx] <= data_f;
                        if (bit_idx == 3'd7)
                            state <= PARITY;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                    PARITY: begin
                        parity <= data_f;
                        state  <= STOP;
                    end
                    STOP: begin
                        if (data_f && ((^shift) ^ parity)) begin
                            data  <= shift;
                            valid <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    error <= 1'b1;
                    state <= IDLE;
                end else begin
                    to_cnt <= to_cnt + CNT_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames on the pins and checks every
// strobe and the held data byte against an event-queue model.
module tb_ps2_rx;

    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int HALF = 40;
    localparam int LAT  = FL + 4;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       valid;
    logic       error;
    logic       busy;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data     (data),
        .valid    (valid),
        .error    (error),
        .busy     (busy)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] b;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_data;
    int         cyc;
    int         n_cmp;
    int         n_bad;
    int         n_valid;
    int         last_fall_cyc;
    int         last_valid_cyc;
    int         last_err_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first nbits of an 11-bit frame; the stop-bit fall schedules the outcome
    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_v,
                              input int nbits, input bit glitch);
        logic [10:0] fr;
        bit          good;
        ev_t         ev;
        fr = {stop_v, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (glitch && i == 4) begin
                step(10);
                ps2_clk = 1'b0;
                step(3);
                ps2_clk = 1'b1;
                step(10);
                ps2_data = ~fr[i];
                step(3);
                ps2_data = fr[i];
                step(HALF - 26);
            end else begin
                step(HALF);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            if (i == 10) begin
                good      = (fr[10] == 1'b1) && ($countones(fr[9:1]) % 2 == 1);
                ev.is_err = !good;
                ev.b      = b;
                ev.cyc    = cyc + LAT;
                exp_q.push_back(ev);
            end
            step(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // Per-cycle compare of strobes and held byte against the expected-event queue
    always @(negedge clk) begin : cmp
        bit due;
        bit exp_v;
        bit exp_e;
        if (!reset) begin
            due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            if (valid || error || due) begin
                exp_v = due && !exp_q[0].is_err;
                exp_e = due && exp_q[0].is_err;
                if (exp_v) model_data = exp_q[0].b;
                n_cmp++;
                if (valid !== exp_v || error !== exp_e) begin
                    n_bad++;
                    $display("FAIL strobe: valid=%b error=%b expected valid=%b error=%b (cycle %0d)",
                             valid, error, exp_v, exp_e, cyc);
                end
                if (valid) begin
                    last_valid_cyc = cyc;
                    n_valid++;
                end
                if (error) last_err_cyc = cyc;
                if (due) void'(exp_q.pop_front());
            end
            n_cmp++;
            if (data !== model_data) begin
                n_bad++;
                $display("FAIL data_hold: got %h expected %h (cycle %0d)", data, model_data, cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0; n_valid = 0;
        last_fall_cyc = 0; last_valid_cyc = -1; last_err_cyc = -1;
        model_data = 8'h00;
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        step(5);
        chk("reset_data", int'(data), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_error", int'(error), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;
        step(5);

        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        step(30);
        chk("frame_1c_data", int'(data), 'h1C);
        chk("frame_1c_latency", last_valid_cyc - last_fall_cyc, 12);
        chk("frame_1c_busy_idle", int'(busy), 0);

        send_frame(8'hE0, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1, 11, 1'b0);
        step(30);
        chk("b2b_data", int'(data), 'h75);
        chk("b2b_valid_count", n_valid, 4);

        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        step(30);
        chk("parity_err_data_held", int'(data), 'h75);
        chk("parity_err_latency", last_err_cyc - last_fall_cyc, 12);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        step(30);
        chk("stop_err_data_held", int'(data), 'h75);
        chk("stop_err_latency", last_err_cyc - last_fall_cyc, 12);

        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b1);
        step(30);
        chk("glitch_data", int'(data), 'h5A);
        chk("glitch_valid_count", n_valid, 5);

        begin : timeout_case
            ev_t ev;
            send_frame(8'h33, 1'b0, 1'b1, 5, 1'b0);
            ev.is_err = 1'b1;
            ev.b      = 8'h00;
            ev.cyc    = last_fall_cyc + LAT + TO;
            exp_q.push_back(ev);
            step(100);
            chk("timeout_busy_mid", int'(busy), 1);
            step(300);
            chk("timeout_busy_after", int'(busy), 0);
            chk("timeout_latency", last_err_cyc - last_fall_cyc, 312);
        end
        send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
        step(30);
        chk("after_timeout_data", int'(data), 'h29);

        send_frame(8'h16, 1'b0, 1'b1, 6, 1'b0);
        step(20);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        model_data = 8'h00;
        #2;
        chk("midreset_data", int'(data), 0);
        chk("midreset_valid", int'(valid), 0);
        chk("midreset_error", int'(error), 0);
        chk("midreset_busy", int'(busy), 0);
        step(4);
        reset = 1'b0;
        step(5);
        send_frame(8'h16, 1'b0, 1'b1, 11, 1'b0);
        step(30);
        chk("after_reset_data", int'(data), 'h16);
        chk("total_valid_count", n_valid, 7);

        step(50);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host serial receiver. It sits directly upstream of the keyboard matrix decoder and turns the raw ps2_clk/ps2_data pin pair into scan-code bytes. Each complete frame yields one byte with a single-cycle valid strobe; malformed or stalled frames yield a single-cycle error strobe. Receive only: no host-to-device transmit and no clock inhibit.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronized samples required before the filtered clock/data level changes (range 2..16)
TIMEOUT_CYCLES, 50000, clocks allowed between successive filtered clock falling edges inside a frame before the frame is aborted (about 2 ms at 25 MHz)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk, idle high
ps2_data  in  1  raw PS/2 data pin, asynchronous to clk, idle high
data  out  8  last correctly received byte; held until the next good frame
valid  out  1  one-clock pulse; data is new in that cycle
error  out  1  one-clock pulse on a parity, stop-bit or timeout failure
busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (asynchronous, active-high): data=0x00, valid=0, error=0, busy=0. State goes to IDLE. Sync flops, filter histories and filtered levels are all set to 1. Timeout counter is cleared.
- Synchronizer: each pin passes through 2 flops (s1, s2).
- Filter: each synchronized signal has a FILTER_LEN-deep shift history. The filtered register goes to 1 when the history is all ones, goes to 0 when it is all zeros, and otherwise holds. Clock and data use identical filtering, so they have identical delay.
- Edge detect: clk_f_d is clk_f delayed one clock. fall = clk_f_d & ~clk_f. The FSM acts only in cycles where fall=1.
- FSM states: IDLE, DATA, PARITY, STOP. Bit index is 3 bits; the shift register is 8 bits, filled LSB first.
  - IDLE, on fall: if data_f=0 (start bit), go to DATA, clear the bit index and clear the timeout counter. If data_f=1, stay in IDLE with no error (spurious edge).
  - DATA, on fall: shift data_f into bit[index]. When index=7, go to PARITY; otherwise increment the index.
  - PARITY, on fall: latch data_f as the parity bit and go to STOP.
  - STOP, on fall: if data_f=1 and (XOR of the 8 data bits XOR parity)=1 (odd parity), load data, pulse valid and go to IDLE. Otherwise pulse error, leave data unchanged and go to IDLE.
- valid and error are registered, high for exactly one clock, and never high in the same cycle.
- Latency: with clean pins, valid (or error) rises exactly FILTER_LEN+4 clocks after the stop-bit falling edge at the ps2_clk pin.
- Timeout: the counter increments every clock while state != IDLE and clears on every fall. When it reaches TIMEOUT_CYCLES-1 with no fall in that cycle: pulse error, go to IDLE. If fall and timeout coincide, fall wins and the frame continues.
- Glitches: a pulse shorter than FILTER_LEN clocks on either pin produces no edge and no state change.
- Back-to-back frames (e.g. 0xE0, 0xF0, 0x75) each produce their own valid pulse. No minimum inter-frame gap is required beyond the stop bit.
- Reset asserted mid-frame aborts the frame immediately with no valid or error pulse. After release, the next frame is received normally.
- busy follows state combinationally from the state register: 1 in DATA, PARITY and STOP.

Test Plan:
- Frame 0x1C (start 0, bits LSB first 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz PS/2 clock -> exactly one valid pulse, data=0x1C, error stays 0; valid rises FILTER_LEN+4 clocks after the stop-bit clock fall.
- Sequence 0xE0, 0xF0, 0x75 back-to-back -> three valid pulses, data=0xE0, then 0xF0, then 0x75 in order; no error.
- Frame 0x1C with parity bit 1 -> one error pulse, no valid, data keeps its previous value. Frame 0x1C with correct parity but stop bit 0 -> same result.
- Frame 0x5A with a 3-clock low glitch on ps2_clk mid-bit and a 3-clock glitch on ps2_data while clock is high (FILTER_LEN=8) -> valid with data=0x5A, no error.
- Send start plus 4 data bits, then hold both pins high -> error pulse exactly TIMEOUT_CYCLES clocks after the last filtered fall, busy drops to 0; a following clean frame 0x29 -> valid, data=0x29.
- Assert reset after the 5th data bit of frame 0x16 -> all outputs 0 at once, no pulses; after release, a clean frame 0x16 -> valid, data=0x16.
